// File: rtl/seg_disp_pkg.sv
`default_nettype none
//==============================================================================
// seg_disp_pkg - shared types and frame builder for the 7-seg display path. Rev 1.0
//==============================================================================
package seg_disp_pkg;

  localparam int FRAME_W = 16;
  localparam int SEG_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_e;

  // Segment byte in the low half, one-hot digit select above it.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [2:0]       idx,
    input logic [SEG_W-1:0] seg,
    input logic             blank
  );
    logic [FRAME_W-1:0] w;
    w = '0;
    w[SEG_W + int'(idx)] = 1'b1;
    if (!blank) begin
      w[SEG_W-1:0] = seg;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_tick_gen.sv
`default_nettype none
//==============================================================================
// refresh_tick_gen - free-running refresh counter with a one-cycle terminal tick. Rev 1.0
//==============================================================================
module refresh_tick_gen #(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_frame_scheduler.sv
`default_nettype none
//==============================================================================
// seg_frame_scheduler - loads, shifts and latches one display frame per refresh tick. Rev 1.0
//==============================================================================
module seg_frame_scheduler
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_DIGITS*8-1:0]   digit_data,
  input  logic                      blank,
  output logic                      sr_ena,
  output logic                      sr_write,
  output logic [15:0]               sr_word,
  output logic                      sclk,
  output logic                      rclk,
  output logic                      busy,
  output logic [2:0]                digit_idx
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [3:0]      BIT_LAST   = 4'(FRAME_W - 1);
  localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic tick;

  refresh_tick_gen #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  state_e               state_q,     state_d;
  logic [PH_W-1:0]      phase_q,     phase_d;
  logic [3:0]           bit_q,       bit_d;
  logic                 pending_q,   pending_d;
  logic [2:0]           digit_idx_q, digit_idx_d;
  logic                 sr_ena_q,    sr_ena_d;
  logic                 sr_write_q,  sr_write_d;
  logic [FRAME_W-1:0]   sr_word_q,   sr_word_d;
  logic                 sclk_q,      sclk_d;
  logic                 rclk_q,      rclk_d;
  logic                 busy_q,      busy_d;
  logic [SEG_W-1:0]     seg_sel;

  always_comb begin
    seg_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == 3'(i)) begin
        seg_sel = digit_data[i*SEG_W +: SEG_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    pending_d   = pending_q;
    digit_idx_d = digit_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT_LO;
        phase_d = '0;
        bit_d   = '0;
      end
      ST_SHIFT_LO: begin
        if (phase_q == PH_LAST) begin
          state_d = ST_SHIFT_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = ST_SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_q == PH_LAST) begin
          state_d     = ST_IDLE;
          phase_d     = '0;
          digit_idx_d = (digit_idx_q == DIGIT_LAST) ? 3'd0 : digit_idx_q + 3'd1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    if (tick && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q.
    sr_write_d = (state_d == ST_LOAD);
    sr_ena_d   = (state_d == ST_LOAD) ||
                 ((state_d == ST_SHIFT_HI) && (phase_d == PH_LAST) && (bit_d != BIT_LAST));
    sr_word_d  = (state_d == ST_LOAD) ? build_frame(digit_idx_q, seg_sel, blank) : sr_word_q;
    sclk_d     = (state_d == ST_SHIFT_HI);
    rclk_d     = (state_d == ST_LATCH);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      pending_q   <= 1'b0;
      digit_idx_q <= '0;
      sr_ena_q    <= 1'b0;
      sr_write_q  <= 1'b0;
      sr_word_q   <= '0;
      sclk_q      <= 1'b0;
      rclk_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      pending_q   <= pending_d;
      digit_idx_q <= digit_idx_d;
      sr_ena_q    <= sr_ena_d;
      sr_write_q  <= sr_write_d;
      sr_word_q   <= sr_word_d;
      sclk_q      <= sclk_d;
      rclk_q      <= rclk_d;
      busy_q      <= busy_d;
    end
  end

  assign sr_ena    = sr_ena_q;
  assign sr_write  = sr_write_q;
  assign sr_word   = sr_word_q;
  assign sclk      = sclk_q;
  assign rclk      = rclk_q;
  assign busy      = busy_q;
  assign digit_idx = digit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_scheduler.sv
`default_nettype none
//==============================================================================
// tb_seg_frame_scheduler - scoreboard bench with a serializer model and frame reference. Rev 1.0
//==============================================================================
module tb_seg_frame_scheduler;

  localparam int N   = 6;
  localparam int DIV = 2;
  localparam int R   = 80;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*8-1:0] digit_data;
  logic          blank;
  logic          sr_ena, sr_write, sclk, rclk, busy;
  logic [15:0]   sr_word;
  logic [2:0]    digit_idx;

  seg_frame_scheduler #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .REFRESH_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .blank(blank),
    .sr_ena(sr_ena), .sr_write(sr_write), .sr_word(sr_word), .sclk(sclk),
    .rclk(rclk), .busy(busy), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;
    logic [15:0] word;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   p;
  int   frames_done = 0;
  logic [15:0] ser_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Posedges since reset release; ticks are expected at multiples of R.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= 0;
    else        p <= p + 1;
  end

  // External serializer: parallel load or shift right.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ser_q <= '0;
    else if (sr_ena && sr_write)  ser_q <= sr_word;
    else if (sr_ena)              ser_q <= {1'b0, ser_q[15:1]};
  end

  // Reference: each tick produces a frame for the next digit, sampled at the LOAD edge.
  initial begin : model
    int midx;
    midx = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        midx = 0;
        exp_q.delete();
      end else if (((p + 1) % R) == 0) begin
        exp_t e;
        logic [7:0] seg;
        seg    = 8'((digit_data >> (8 * midx)) & 48'hFF);
        e.p    = p + 1;
        e.idx  = midx;
        e.word = 16'(32'h1 << (8 + midx)) | (blank ? 16'h0000 : {8'h00, seg});
        exp_q.push_back(e);
        midx = (midx + 1) % N;
      end
    end
  end

  initial begin : monitor
    exp_t        cur;
    logic        in_frame, sclk_prev;
    int          shifts, rises, rclks, since;
    logic [15:0] bits;
    in_frame = 0; sclk_prev = 0; shifts = 0; rises = 0; rclks = 0; since = 0; bits = '0;
    cur = '{p: 0, word: 16'h0, idx: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; sclk_prev = 0; shifts = 0; rises = 0; rclks = 0; since = 0;
      end else begin
        if (sclk && !sclk_prev) begin
          chk("sclk_setup", (since >= DIV), 1);
          if (rises < 16) bits[rises] = ser_q[0];
          rises++;
        end
        if (sr_ena) since = 0;
        else        since++;
        if (rclk) rclks++;
        if (sr_ena && !sr_write) shifts++;
        if (sr_ena && sr_write) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_load", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("load_cycle", p, cur.p);
            chk("load_word", sr_word, cur.word);
            chk("load_digit", digit_idx, cur.idx);
            chk("load_busy", busy, 1);
          end
          in_frame = 1; shifts = 0; rises = 0; rclks = 0; bits = '0;
        end else if (in_frame && !busy) begin
          chk("shift_count", shifts, 15);
          chk("sclk_rises", rises, 16);
          chk("rclk_cycles", rclks, DIV);
          chk("serial_word", bits, cur.word);
          chk("next_digit", digit_idx, (cur.idx + 1) % N);
          in_frame = 0;
          frames_done++;
        end
        sclk_prev = sclk;
      end
    end
  end

  initial begin : watchdog
    repeat (8000) @(negedge clk);
    errors++;
    $display("FAIL watchdog timeout frames=%0d expected=17", frames_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic wait_p(input int target);
    while (p != target) @(negedge clk);
  endtask

  task automatic set_frame(input int k);
    int d;
    d = k % N;
    digit_data = {16'($urandom), $urandom};
    blank      = ($urandom_range(0, 4) == 0);
    if (k == 0) begin
      digit_data[7:0] = 8'h3F;
      blank = 1'b0;
    end
    if (k == 3) begin
      digit_data[8*d +: 8] = 8'h66;
      blank = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sr_ena"},   sr_ena,    0);
    chk({tag, "_sr_write"}, sr_write,  0);
    chk({tag, "_sr_word"},  sr_word,   16'h0000);
    chk({tag, "_sclk"},     sclk,      0);
    chk({tag, "_rclk"},     rclk,      0);
    chk({tag, "_busy"},     busy,      0);
    chk({tag, "_digit"},    digit_idx, 0);
  endtask

  initial begin : stim
    rst_n = 1'b0;
    set_frame(0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Data changes land mid-frame, after LOAD has already captured the frame.
    for (int k = 0; k < 14; k++) begin
      wait_p((k + 1) * R + R / 2);
      chk("midframe_busy", busy, 1);
      set_frame(k + 1);
    end

    // Abort frame 14 during the high phase of bit 7.
    wait_p(15 * R + 1 + 7 * 2 * DIV + DIV);
    chk("bit7_sclk_high", sclk, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_outputs("held_reset");
    set_frame(0);
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      wait_p((k + 1) * R + R / 2);
      set_frame(k + 1);
    end
    wait_p(3 * R + 70);
    chk("frames_done", frames_done, 17);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
